// File: rtl/sme_pkg.sv
// Shared constants and the controller state type for the multi-PE string matcher.
package sme_pkg;

  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_STR = 3'd1,
    ST_LOAD_PAT = 3'd2,
    ST_SEARCH   = 3'd3,
    ST_DONE     = 3'd4
  } sme_state_t;

endpackage

// File: rtl/sme_pe.sv
// One processing element: decides whether the core pattern, with its anchor
// conditions, matches the string window starting at a single candidate index.
module sme_pe
  import sme_pkg::*;
#(
  parameter int PAT_MAX = 8,
  parameter int PL_W    = $clog2(PAT_MAX + 1)
) (
  input  logic [PAT_MAX-1:0][7:0] i_win,
  input  logic [PAT_MAX-1:0][7:0] i_core,
  input  logic [PL_W-1:0]         i_core_len,
  input  logic                    i_anc_s,
  input  logic                    i_anc_e,
  input  logic [7:0]              i_prev,
  input  logic [7:0]              i_next,
  output logic                    o_hit
);

  logic w_core_ok;

  // Every position inside the core must agree; a '.' accepts any string char
  always_comb begin
    w_core_ok = 1'b1;
    for (int k = 0; k < PAT_MAX; k++) begin
      if ((PL_W'(k) < i_core_len) && (i_core[k] != CH_DOT) && (i_core[k] != i_win[k])) begin
        w_core_ok = 1'b0;
      end else begin
        w_core_ok = w_core_ok;
      end
    end
  end

  assign o_hit = w_core_ok
               & (~i_anc_s | (i_prev == CH_SPACE))
               & (~i_anc_e | (i_next == CH_SPACE));

endmodule

// File: rtl/sme_multi_pe.sv
// String-matching engine: byte-serial string/pattern load, then NUM_PE start
// positions per SEARCH cycle with '.', '^' and '$' support and string reuse.
module sme_multi_pe
  import sme_pkg::*;
#(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int NUM_PE  = 4,
  parameter int IDX_W   = $clog2(STR_MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index
);

  localparam int LEN_W = $clog2(STR_MAX + 1);
  localparam int CW    = LEN_W + 1;
  localparam int PL_W  = $clog2(PAT_MAX + 1);

  sme_state_t r_state;
  sme_state_t w_state_nxt;

  logic [7:0]              r_str [STR_MAX];
  logic [LEN_W-1:0]        r_str_len;
  logic                    r_new_str;
  logic [PAT_MAX-1:0][7:0] r_pat;
  logic [PL_W-1:0]         r_pat_len;
  logic [PAT_MAX-1:0][7:0] r_core;
  logic [PL_W-1:0]         r_core_len;
  logic                    r_anc_s;
  logic                    r_anc_e;
  logic [CW-1:0]           r_base;
  logic                    r_valid;
  logic                    r_match;
  logic [IDX_W-1:0]        r_match_index;

  logic                    w_str_we;
  logic                    w_pat_first;
  logic                    w_pat_app;
  logic                    w_search_start;
  logic                    w_searching;
  logic                    w_done;
  logic                    w_resolve;
  logic [LEN_W-1:0]        w_str_idx;
  logic                    w_anc_s;
  logic                    w_anc_e;
  logic [7:0]              w_last_ch;
  logic [PL_W-1:0]         w_core_len;
  logic [PAT_MAX-1:0][7:0] w_core;
  logic [CW-1:0]           w_l_ext;
  logic [CW-1:0]           w_len_ext;
  logic [CW-1:0]           w_ncand;
  logic                    w_last_grp;
  logic [NUM_PE-1:0]       w_pe_hit;
  logic [NUM_PE-1:0]       w_inrange;
  logic                    w_any;
  logic [IDX_W-1:0]        w_sel;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ispattern takes priority over isstring
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ispattern)     w_state_nxt = ST_LOAD_PAT;
        else if (isstring) w_state_nxt = ST_LOAD_STR;
        else               w_state_nxt = ST_IDLE;
      end
      ST_LOAD_STR: begin
        if (ispattern) w_state_nxt = ST_LOAD_PAT;
        else           w_state_nxt = ST_LOAD_STR;
      end
      ST_LOAD_PAT: begin
        if (ispattern) w_state_nxt = ST_LOAD_PAT;
        else           w_state_nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (w_resolve) w_state_nxt = ST_DONE;
        else           w_state_nxt = ST_SEARCH;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    w_str_we       = 1'b0;
    w_pat_first    = 1'b0;
    w_pat_app      = 1'b0;
    w_search_start = 1'b0;
    w_searching    = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD_STR: begin
        w_pat_first = ispattern;
        w_str_we    = isstring & ~ispattern;
      end
      ST_LOAD_PAT: begin
        w_pat_app      = ispattern;
        w_search_start = ~ispattern;
      end
      ST_SEARCH: w_searching = 1'b1;
      ST_DONE:   w_done      = 1'b1;
      default:   w_done      = 1'b0;
    endcase
  end

  // A fresh string always starts at slot 0; r_new_str is re-armed after every result
  assign w_str_idx = r_new_str ? {LEN_W{1'b0}} : r_str_len;

  // String length and new-string flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_str_len <= {LEN_W{1'b0}};
      r_new_str <= 1'b1;
    end else if (w_str_we) begin
      r_new_str <= 1'b0;
      if (r_new_str) begin
        r_str_len <= LEN_W'(1);
      end else if (r_str_len < LEN_W'(STR_MAX)) begin
        r_str_len <= r_str_len + LEN_W'(1);
      end
    end else if (w_done) begin
      r_new_str <= 1'b1;
    end
  end

  // String buffer; characters past STR_MAX are dropped
  always_ff @(posedge clk) begin
    if (w_str_we && (w_str_idx < LEN_W'(STR_MAX))) begin
      r_str[IDX_W'(w_str_idx)] <= chardata;
    end
  end

  // Pattern length, saturating at PAT_MAX
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat_len <= {PL_W{1'b0}};
    end else if (w_pat_first) begin
      r_pat_len <= PL_W'(1);
    end else if (w_pat_app && (r_pat_len < PL_W'(PAT_MAX))) begin
      r_pat_len <= r_pat_len + PL_W'(1);
    end
  end

  // Pattern buffer
  always_ff @(posedge clk) begin
    for (int k = 0; k < PAT_MAX; k++) begin
      if ((w_pat_first && (k == 0)) || (w_pat_app && (r_pat_len == PL_W'(k)))) begin
        r_pat[k] <= chardata;
      end
    end
  end

  // Anchor decode and core extraction from the finished pattern
  always_comb begin
    w_anc_s   = (r_pat[0] == CH_CARET);
    w_last_ch = r_pat[0];
    for (int k = 0; k < PAT_MAX; k++) begin
      if (r_pat_len == PL_W'(k + 1)) w_last_ch = r_pat[k];
      else                           w_last_ch = w_last_ch;
    end
    w_anc_e    = (w_last_ch == CH_DOLLAR) && (r_pat_len > PL_W'(w_anc_s));
    w_core_len = r_pat_len - PL_W'(w_anc_s) - PL_W'(w_anc_e);
    w_core     = w_anc_s ? (r_pat >> 4'd8) : r_pat;
  end

  // Latched search context and group base
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_len <= {PL_W{1'b0}};
      r_anc_s    <= 1'b0;
      r_anc_e    <= 1'b0;
      r_base     <= {CW{1'b0}};
    end else if (w_search_start) begin
      r_core     <= w_core;
      r_core_len <= w_core_len;
      r_anc_s    <= w_anc_s;
      r_anc_e    <= w_anc_e;
      r_base     <= {CW{1'b0}};
    end else if (w_searching && !w_resolve) begin
      r_base <= r_base + CW'(NUM_PE);
    end
  end

  // Candidate count: none if the core is longer than the string, only i=0 for an empty core
  always_comb begin
    w_l_ext   = CW'(r_core_len);
    w_len_ext = CW'(r_str_len);
    if (w_l_ext > w_len_ext)              w_ncand = {CW{1'b0}};
    else if (r_core_len == {PL_W{1'b0}})  w_ncand = CW'(1);
    else                                  w_ncand = w_len_ext - w_l_ext + CW'(1);
  end

  assign w_last_grp = ((r_base + CW'(NUM_PE)) >= w_ncand);

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    logic [CW-1:0]           w_cand;
    logic [CW-1:0]           w_widx;
    logic [CW-1:0]           w_pidx;
    logic [CW-1:0]           w_end;
    logic [PAT_MAX-1:0][7:0] w_win;
    logic [7:0]              w_prev;
    logic [7:0]              w_next;

    // Window and boundary characters; positions outside the buffer read as blank
    always_comb begin
      w_cand = r_base + CW'(p);
      w_end  = w_cand + w_l_ext;
      w_pidx = w_cand - CW'(1);
      w_widx = {CW{1'b0}};
      w_win  = {(PAT_MAX * 8){1'b0}};
      for (int k = 0; k < PAT_MAX; k++) begin
        w_widx = w_cand + CW'(k);
        if (w_widx < CW'(STR_MAX)) w_win[k] = r_str[IDX_W'(w_widx)];
        else                       w_win[k] = 8'h00;
      end
      if (w_cand == {CW{1'b0}})          w_prev = CH_SPACE;
      else if (w_pidx < CW'(STR_MAX))    w_prev = r_str[IDX_W'(w_pidx)];
      else                               w_prev = CH_SPACE;
      if (w_end == w_len_ext)            w_next = CH_SPACE;
      else if (w_end < CW'(STR_MAX))     w_next = r_str[IDX_W'(w_end)];
      else                               w_next = CH_SPACE;
    end

    assign w_inrange[p] = (w_cand < w_ncand);

    sme_pe #(
      .PAT_MAX (PAT_MAX),
      .PL_W    (PL_W)
    ) u_pe (
      .i_win      (w_win),
      .i_core     (r_core),
      .i_core_len (r_core_len),
      .i_anc_s    (r_anc_s),
      .i_anc_e    (r_anc_e),
      .i_prev     (w_prev),
      .i_next     (w_next),
      .o_hit      (w_pe_hit[p])
    );
  end

  // Lowest in-range hit wins
  always_comb begin
    w_any = 1'b0;
    w_sel = {IDX_W{1'b0}};
    for (int j = NUM_PE - 1; j >= 0; j--) begin
      if (w_pe_hit[j] && w_inrange[j]) begin
        w_any = 1'b1;
        w_sel = IDX_W'(r_base + CW'(j));
      end else begin
        w_any = w_any;
        w_sel = w_sel;
      end
    end
  end

  assign w_resolve = w_searching & (w_any | w_last_grp);

  // Result registers; match and index hold between results
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_match       <= 1'b0;
      r_match_index <= {IDX_W{1'b0}};
    end else if (w_resolve) begin
      r_valid       <= 1'b1;
      r_match       <= w_any;
      r_match_index <= w_any ? w_sel : {IDX_W{1'b0}};
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign valid       = r_valid;
  assign match       = r_match;
  assign match_index = r_match_index;

endmodule

// File: tb/tb_sme_multi_pe.sv
// Scoreboard bench for sme_multi_pe: directed scenarios plus randomized
// string/pattern runs checked against a plain-arithmetic reference search.
module tb_sme_multi_pe;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int NUM_PE  = 4;
  localparam int IDX_W   = $clog2(STR_MAX);

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit    m;
    int    idx;
    int    cyc;
    string name;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       chardata;
  logic             isstring;
  logic             ispattern;
  logic             valid;
  logic             match;
  logic [IDX_W-1:0] match_index;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t mon_e;
  bq_t  m_str;

  sme_multi_pe #(
    .STR_MAX (STR_MAX),
    .PAT_MAX (PAT_MAX),
    .NUM_PE  (NUM_PE),
    .IDX_W   (IDX_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected result
  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_match"}, int'(match), int'(mon_e.m));
        check({mon_e.name, "_index"}, int'(match_index), mon_e.idx);
        check({mon_e.name, "_latency"}, cyc, mon_e.cyc);
      end
    end
  end

  function automatic void s2q(input string s, output bq_t q);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  // Reference search: direct scan of start positions over the stored string
  function automatic void ref_search(input bq_t s, input bq_t p,
                                     output bit m, output int idx, output int g);
    int  n;
    int  pl;
    int  L;
    int  ncand;
    bit  as;
    bit  ae;
    bit  ok;
    bq_t core;
    n  = s.size();
    pl = p.size();
    as = (p[0] == 8'h5E);
    ae = (p[pl-1] == 8'h24) && (pl > int'(as));
    for (int k = int'(as); k < pl - int'(ae); k++) core.push_back(p[k]);
    L = core.size();
    if (L > n)       ncand = 0;
    else if (L == 0) ncand = 1;
    else             ncand = n - L + 1;
    m   = 1'b0;
    idx = 0;
    for (int i = 0; i < ncand && !m; i++) begin
      ok = 1'b1;
      for (int k = 0; k < L; k++)
        if (core[k] != 8'h2E && core[k] != s[i+k]) ok = 1'b0;
      if (as && i != 0 && s[i-1] != 8'h20) ok = 1'b0;
      if (ae && (i + L) != n && s[i+L] != 8'h20) ok = 1'b0;
      if (ok) begin
        m   = 1'b1;
        idx = i;
      end
    end
    if (m)               g = idx / NUM_PE + 1;
    else if (ncand == 0) g = 1;
    else                 g = (ncand + NUM_PE - 1) / NUM_PE;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_string(input bq_t s, input bit gaps);
    m_str.delete();
    for (int i = 0; i < s.size(); i++) begin
      isstring  = 1'b1;
      ispattern = 1'b0;
      chardata  = s[i];
      if (m_str.size() < STR_MAX) m_str.push_back(s[i]);
      tick();
      if (gaps && $urandom_range(0, 3) == 0) begin
        isstring = 1'b0;
        tick();
      end
    end
    isstring = 1'b0;
  endtask

  // Sends a pattern, then queues the expected result once the SEARCH edge is known
  task automatic run_pattern(input bq_t p, input bit use_ref, input bit em, input int ei,
                             input int eg, input string name, input bit noise);
    bq_t pq;
    bit  rm;
    int  ri;
    int  rg;
    for (int i = 0; i < p.size(); i++) begin
      ispattern = 1'b1;
      isstring  = (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      chardata  = p[i];
      if (pq.size() < PAT_MAX) pq.push_back(p[i]);
      tick();
    end
    ispattern = 1'b0;
    isstring  = 1'b0;
    if (use_ref) begin
      ref_search(m_str, pq, rm, ri, rg);
    end else begin
      rm = em;
      ri = ei;
      rg = eg;
    end
    tick();
    sb.push_back('{rm, ri, cyc + rg, name});
    if (noise) begin
      chardata = 8'h21;
      if ($urandom_range(0, 1) == 0) isstring = 1'b1;
      else                           ispattern = 1'b1;
      tick();
      isstring  = 1'b0;
      ispattern = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no valid after %0d cycles expected %0d pending results", n, sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_match"}, int'(match), 0);
    check({tag, "_index"}, int'(match_index), 0);
  endtask

  initial begin
    bq_t   sq;
    bq_t   pq;
    string s40;
    string alpha_s;
    string alpha_p;
    int    n;
    bit    reuse;

    alpha_s   = "ab ";
    alpha_p   = "ab.^$ ";
    reset     = 1'b1;
    chardata  = 8'h00;
    isstring  = 1'b0;
    ispattern = 1'b0;
    repeat (3) tick();
    reset_checks("reset");
    reset = 1'b0;
    tick();

    s2q("hello world", sq); load_string(sq, 1'b0);
    s2q("wor", pq);  run_pattern(pq, 1'b0, 1'b1, 6, 2, "wor", 1'b0);  wait_done();
    s2q("^wor", pq); run_pattern(pq, 1'b0, 1'b1, 6, 2, "caret_wor", 1'b0); wait_done();
    s2q("^orl", pq); run_pattern(pq, 1'b0, 1'b0, 0, 3, "caret_orl", 1'b0); wait_done();
    s2q("ld$", pq);  run_pattern(pq, 1'b0, 1'b1, 9, 3, "ld_dollar", 1'b0); wait_done();
    s2q("h.l", pq);  run_pattern(pq, 1'b0, 1'b1, 0, 1, "h_dot_l", 1'b1); wait_done();
    s2q("o", pq);    run_pattern(pq, 1'b0, 1'b1, 4, 2, "reuse_o", 1'b0); wait_done();

    s40 = "";
    for (int i = 0; i < 32; i++) s40 = {s40, "a"};
    s40 = {s40, "zzzzzzzz"};
    s2q(s40, sq); load_string(sq, 1'b0);
    s2q("z", pq);  run_pattern(pq, 1'b0, 1'b0, 0, 8, "str_overflow_z", 1'b0); wait_done();
    s2q("a$", pq); run_pattern(pq, 1'b0, 1'b1, 31, 8, "str_overflow_end", 1'b0); wait_done();

    s2q("abcdefghij", sq); load_string(sq, 1'b0);
    s2q("abcdefghX", pq); run_pattern(pq, 1'b0, 1'b1, 0, 1, "pat_overflow", 1'b0); wait_done();

    s2q("ab", sq); load_string(sq, 1'b0);
    s2q("abc", pq); run_pattern(pq, 1'b0, 1'b0, 0, 1, "pat_longer", 1'b0); wait_done();

    s2q("xxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxx", sq); load_string(sq, 1'b0);
    s2q("zz", pq); run_pattern(pq, 1'b0, 1'b0, 0, 8, "aborted", 1'b0);
    tick();
    tick();
    reset = 1'b1;
    sb.delete();
    tick();
    reset_checks("mid_search_reset");
    reset = 1'b0;
    repeat (10) tick();
    s2q("ab", sq); load_string(sq, 1'b0);
    s2q("b", pq); run_pattern(pq, 1'b0, 1'b1, 1, 1, "after_reset", 1'b0); wait_done();

    for (int t = 0; t < 40; t++) begin
      reuse = ($urandom_range(0, 3) == 0);
      if (!reuse) begin
        sq.delete();
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) sq.push_back(alpha_s[$urandom_range(0, 2)]);
        load_string(sq, 1'b1);
      end
      pq.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) pq.push_back(alpha_p[$urandom_range(0, 5)]);
      if ($urandom_range(0, 3) == 0) pq[0] = 8'h5E;
      if ($urandom_range(0, 3) == 0) pq[n-1] = 8'h24;
      run_pattern(pq, 1'b1, 1'b0, 0, 0, "rand", 1'($urandom_range(0, 1)));
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
